col_stream: RTL and testbench

Column streamer that sits directly downstream of the im2col stage. It captures the 12-column by 288-element patch matrix in one cycle and replays it to the MAC array. Each handshake beat carries one channel's 3x3 window, which is 9 elements. Full valid/ready flow control lets the consumer stall at any beat without losing or reordering data.

---
 rtl/col_stream.sv | 105 ++++++++++
 tb/tb_col_stream.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/col_stream.sv
// Column streamer: captures the im2col patch matrix in one cycle and replays it one 3x3
// channel window per valid/ready beat. Optional COL_STREAM_REPLAY_EN adds a replay input.
module col_stream #(
  parameter int unsigned DATA_LEN = 8,
  parameter int unsigned N_COL    = 12,
  parameter int unsigned N_CH     = 32
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             load,
`ifdef COL_STREAM_REPLAY_EN
  input  logic                             replay,
`endif
  input  logic [N_COL*N_CH*9*DATA_LEN-1:0] d,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [9*DATA_LEN-1:0]            out_data,
  output logic [3:0]                       out_col,
  output logic [4:0]                       out_ch,
  output logic                             out_last,
  output logic                             busy,
  output logic                             done
);

  localparam int unsigned WinW = 9 * DATA_LEN;
  localparam int unsigned BufW = N_COL * N_CH * 9 * DATA_LEN;
  localparam int unsigned OffW = $clog2(N_COL * N_CH * 9) + $clog2(DATA_LEN);
  localparam logic [3:0]  ColLast = 4'(N_COL - 1);
  localparam logic [4:0]  ChLast  = 5'(N_CH - 1);

  typedef enum logic [1:0] {StIdle, StStream, StDone} state_e;

  state_e            state_q, state_d;
  logic [3:0]        col_q, col_d;
  logic [4:0]        ch_q, ch_d;
  logic [BufW-1:0]   buf_q, buf_d;
  logic              start;
  logic              fire;
  logic              final_beat;
  logic [OffW-1:0]   offset;

`ifdef COL_STREAM_REPLAY_EN
  assign start = load | replay;
`else
  assign start = load;
`endif

  assign fire       = (state_q == StStream) && out_ready;
  assign final_beat = (col_q == ColLast) && (ch_q == ChLast);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      col_q   <= '0;
      ch_q    <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      col_q   <= col_d;
      ch_q    <= ch_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StStream;
      StStream: if (fire && final_beat) state_d = StDone;
      StDone:   state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // Counters clear on entry and after the final beat so out_col/out_ch read 0 when idle.
  always_comb begin
    col_d = col_q;
    ch_d  = ch_q;
    buf_d = buf_q;
    if (state_q == StIdle && start) begin
      col_d = '0;
      ch_d  = '0;
      if (load) buf_d = d;
    end else if (fire) begin
      if (ch_q == ChLast) begin
        ch_d  = '0;
        col_d = final_beat ? 4'd0 : col_q + 4'd1;
      end else begin
        ch_d = ch_q + 5'd1;
      end
    end
  end

  always_comb begin
    out_valid = (state_q == StStream);
    busy      = (state_q == StStream) || (state_q == StDone);
    done      = (state_q == StDone);
    out_col   = col_q;
    out_ch    = ch_q;
    out_last  = (state_q == StStream) && (ch_q == ChLast);
    offset    = (OffW'(col_q) * OffW'(N_CH * 9) + OffW'(ch_q) * OffW'(9)) * OffW'(DATA_LEN);
    out_data  = buf_q[offset +: WinW];
  end

endmodule

// File: tb/tb_col_stream.sv
// Directed bench for col_stream: full streams, stalls, ignored loads, mid-stream reset,
// back-to-back load and (with COL_STREAM_REPLAY_EN) replay.
module tb_col_stream;

  localparam int unsigned DL    = 8;
  localparam int unsigned NCOL  = 12;
  localparam int unsigned NCH   = 32;
  localparam int unsigned NBEAT = NCOL * NCH;
  localparam int unsigned DW    = NCOL * NCH * 9 * DL;

  logic          clk = 1'b0;
  logic          rst;
  logic          load;
`ifdef COL_STREAM_REPLAY_EN
  logic          replay;
`endif
  logic [DW-1:0] d;
  logic          out_valid;
  logic          out_ready;
  logic [9*DL-1:0] out_data;
  logic [3:0]    out_col;
  logic [4:0]    out_ch;
  logic          out_last;
  logic          busy;
  logic          done;

  int errors = 0;
  int checks = 0;

  col_stream #(.DATA_LEN(DL), .N_COL(NCOL), .N_CH(NCH)) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
`ifdef COL_STREAM_REPLAY_EN
    .replay    (replay),
`endif
    .d         (d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_col   (out_col),
    .out_ch    (out_ch),
    .out_last  (out_last),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  // Element n = (n + base) mod 256.
  function automatic logic [DW-1:0] pattern(input int base);
    logic [DW-1:0] v;
    v = '0;
    for (int n = 0; n < int'(NCOL * NCH * 9); n++) v[n*DL +: DL] = 8'(n + base);
    return v;
  endfunction

  // Pulses load for one cycle; returns at the negedge of the first beat cycle.
  task automatic pulse_load();
    @(negedge clk);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Consumes beats up to stop_at, checking every cycle against beat k of pattern base.
  // Stalled cycles recheck the same beat, so held outputs are verified too.
  task automatic drain(input int base, input int stop_at, input bit stall, input bit poke_load,
                       output int got);
    int k;
    int cyc;
    logic rdy;
    logic [9*DL-1:0] exp_data;
    k = 0;
    cyc = 0;
    while (k < stop_at && cyc < 5000) begin
      for (int e = 0; e < 9; e++) exp_data[e*DL +: DL] = 8'(k * 9 + e + base);
      checks++;
      if (out_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
        errors++;
        $display("FAIL stream_flags beat %0d: valid=%b busy=%b done=%b, required 1 1 0",
                 k, out_valid, busy, done);
      end
      checks++;
      if (out_col !== 4'(k / NCH) || out_ch !== 5'(k % NCH)) begin
        errors++;
        $display("FAIL stream_index beat %0d: col=%0d ch=%0d, required %0d %0d",
                 k, out_col, out_ch, k / NCH, k % NCH);
      end
      checks++;
      if (out_last !== ((k % NCH) == NCH - 1)) begin
        errors++;
        $display("FAIL stream_last beat %0d: last=%b", k, out_last);
      end
      checks++;
      if (out_data !== exp_data) begin
        errors++;
        $display("FAIL stream_data beat %0d: got %h, required %h", k, out_data, exp_data);
      end
      load = poke_load && (k == 5 || k == 200);
      rdy = stall ? 1'($urandom_range(0, 1)) : 1'b1;
      out_ready = rdy;
      @(negedge clk);
      if (rdy) k++;
      cyc++;
    end
    load = 1'b0;
    got = k;
    checks++;
    if (k < stop_at) begin
      errors++;
      $display("FAIL drain_timeout: reached beat %0d, required %0d", k, stop_at);
    end
  endtask

  // Checks the done cycle and the return to idle after a completed stream.
  task automatic check_done_then_idle();
    checks++;
    if (done !== 1'b1 || busy !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL done_cycle: done=%b busy=%b valid=%b, required 1 1 0", done, busy, out_valid);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_done: done=%b busy=%b valid=%b, required 0 0 0",
               done, busy, out_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    load = 1'b0;
    out_ready = 1'b0;
`ifdef COL_STREAM_REPLAY_EN
    replay = 1'b0;
`endif
    d = pattern(0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: valid=%b busy=%b done=%b last=%b, required 0",
               out_valid, busy, done, out_last);
    end
    checks++;
    if (out_col !== 4'd0 || out_ch !== 5'd0 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_data: col=%0d ch=%0d data=%h, required 0", out_col, out_ch, out_data);
    end
  endtask

  task automatic test_stream();
    int got;
    d = pattern(0);
    pulse_load();
    drain(0, NBEAT, 1'b0, 1'b0, got);
    check_done_then_idle();
  endtask

  task automatic test_stall();
    int got;
    d = pattern(0);
    pulse_load();
    drain(0, NBEAT, 1'b1, 1'b0, got);
    check_done_then_idle();
  endtask

  task automatic test_load_ignored();
    int got;
    d = pattern(0);
    pulse_load();
    d = pattern(77);
    drain(0, NBEAT, 1'b0, 1'b1, got);
    check_done_then_idle();
  endtask

  task automatic test_reset_mid();
    int got;
    d = pattern(0);
    pulse_load();
    drain(0, 100, 1'b0, 1'b0, got);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_mid: valid=%b busy=%b done=%b data=%h, required all 0",
               out_valid, busy, done, out_data);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_quiet: done=%b valid=%b, required 0 0", done, out_valid);
    end
    d = pattern(3);
    pulse_load();
    drain(3, NBEAT, 1'b0, 1'b0, got);
    check_done_then_idle();
  endtask

  task automatic test_back_to_back();
    int got;
    d = pattern(0);
    pulse_load();
    drain(0, NBEAT, 1'b0, 1'b0, got);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_done: done=%b, required 1", done);
    end
    d = pattern(50);
    load = 1'b1;
    @(negedge clk);
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL b2b_idle: valid=%b busy=%b done=%b, required 0 0 0", out_valid, busy, done);
    end
    @(negedge clk);
    load = 1'b0;
    drain(50, NBEAT, 1'b0, 1'b0, got);
    check_done_then_idle();
  endtask

`ifdef COL_STREAM_REPLAY_EN
  task automatic test_replay();
    int got;
    d = pattern(0);
    pulse_load();
    drain(0, NBEAT, 1'b0, 1'b0, got);
    check_done_then_idle();
    d = pattern(99);
    @(negedge clk);
    replay = 1'b1;
    @(negedge clk);
    replay = 1'b0;
    drain(0, NBEAT, 1'b0, 1'b0, got);
    check_done_then_idle();
    @(negedge clk);
    replay = 1'b1;
    load = 1'b1;
    @(negedge clk);
    replay = 1'b0;
    load = 1'b0;
    drain(99, NBEAT, 1'b0, 1'b0, got);
    check_done_then_idle();
  endtask
`endif

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_load_ignored();
    test_reset_mid();
    test_back_to_back();
`ifdef COL_STREAM_REPLAY_EN
    test_replay();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
